// File: rtl/framebuffer_arbiter.sv
// Framebuffer arbiter: camera writes vs display reads on one single-port RAM; FB_ARB_STATS_EN adds drop/starve counters.
// Latency: a write reaches the RAM bus 1 cycle after it is taken, read data returns 3 cycles after rd_ready.
// Backpressure: reads stall until rd_ready; writes never stall, they are buffered 2 deep or dropped with wr_overflow.

// Small generic FIFO used for the write buffer.
// Latency: pushed data is visible on pop_dat the cycle after the push.
// Backpressure: a push into a full FIFO is accepted only if a pop happens in the same cycle.
module fb_arb_fifo #(
   parameter int W     = 28,
   parameter int DEPTH = 2
) (
   input  logic         pclk,
   input  logic         reset,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_rdy,
   output logic [W-1:0] pop_dat,
   output logic         empty,
   output logic         full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  store [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop_rdy && !empty;
   assign do_push = push_vld && (!full || do_pop);
   assign pop_dat = store[rd_ptr];

   always_ff @(posedge pclk) begin
      if (do_push) begin
         store[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge pclk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end
endmodule

module framebuffer_arbiter #(
   parameter int FB_DEPTH     = 307200,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_overflow,
   input  logic        rd_req,
   input  logic [19:0] rd_addr,
   output logic        rd_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        mem_en,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
`ifdef FB_ARB_STATS_EN
   ,
   output logic [15:0] drop_count,
   output logic [15:0] starve_count
`endif
);
   typedef struct packed {
      logic [19:0] addr;
      logic [7:0]  data;
   } wr_ent_t;

   localparam int            WW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [WW-1:0] LIMIT     = WW'(STARVE_LIMIT);
   localparam logic [20:0]   DEPTH_EXT = 21'(FB_DEPTH);

   wr_ent_t       wr_ent;
   wr_ent_t       fifo_dat;
   wr_ent_t       wr_sel;
   logic          wr_in;
   logic          rd_in;
   logic          rd_in_range;
   logic          fifo_empty;
   logic          fifo_full;
   logic          eff_empty;
   logic          starve;
   logic          grant_rd;
   logic          grant_wr;
   logic          bypass;
   logic          fifo_push;
   logic          fifo_pop;
   logic          drop;
   logic [WW-1:0] wait_cnt;
   logic          p1_vld;
   logic          p1_oor;
   logic          p2_vld;
   logic          p2_oor;

   assign wr_ent      = '{addr: wr_addr, data: wr_data};
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

   // Out-of-range writes vanish here; nothing downstream ever sees them.
   assign wr_in = reset && wr_req && ({1'b0, wr_addr} < DEPTH_EXT);
   assign rd_in = reset && rd_req;

   // The arriving write counts as buffered, so an idle FIFO lets it go straight to RAM.
   assign eff_empty = fifo_empty && !wr_in;
   assign starve    = (wait_cnt >= LIMIT);
   assign grant_rd  = rd_in && (eff_empty || starve);
   assign grant_wr  = !grant_rd && !eff_empty;
   assign bypass    = grant_wr && fifo_empty;
   assign fifo_pop  = grant_wr && !fifo_empty;
   assign fifo_push = wr_in && !bypass;
   assign drop      = fifo_push && fifo_full && !fifo_pop;
   assign wr_sel    = fifo_empty ? wr_ent : fifo_dat;
   assign rd_ready  = grant_rd;

   fb_arb_fifo #(
      .W     ($bits(wr_ent_t)),
      .DEPTH (2)
   ) u_wr_fifo (
      .pclk     (pclk),
      .reset    (reset),
      .push_vld (fifo_push),
      .push_dat (wr_ent),
      .pop_rdy  (fifo_pop),
      .pop_dat  (fifo_dat),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge pclk) begin
      if (!reset) begin
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         wr_overflow <= 1'b0;
         wait_cnt    <= '0;
         p1_vld      <= 1'b0;
         p1_oor      <= 1'b0;
         p2_vld      <= 1'b0;
         p2_oor      <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
      end else begin
         mem_en      <= grant_wr || (grant_rd && rd_in_range);
         mem_we      <= grant_wr;
         wr_overflow <= drop;
         if (grant_wr) begin
            mem_addr  <= wr_sel.addr;
            mem_wdata <= wr_sel.data;
         end else if (grant_rd && rd_in_range) begin
            mem_addr <= rd_addr;
         end

         if (!rd_in || grant_rd) begin
            wait_cnt <= '0;
         end else if (!starve) begin
            wait_cnt <= wait_cnt + WW'(1);
         end

         // RAM answers one cycle after the bus cycle, captured one cycle later.
         p1_vld   <= grant_rd;
         p1_oor   <= !rd_in_range;
         p2_vld   <= p1_vld;
         p2_oor   <= p1_oor;
         rd_valid <= p2_vld;
         rd_data  <= (p2_vld && !p2_oor) ? mem_rdata : 8'h00;
      end
   end

`ifdef FB_ARB_STATS_EN
   always_ff @(posedge pclk) begin
      if (!reset) begin
         drop_count   <= '0;
         starve_count <= '0;
      end else begin
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
         if (grant_rd && !eff_empty && (starve_count != 16'hFFFF)) begin
            starve_count <= starve_count + 16'd1;
         end
      end
   end
`endif
endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter FB_DEPTH, default 307200, number of framebuffer bytes (640x480); valid addresses 0..FB_DEPTH-1.
REQ-002 Parameter STARVE_LIMIT, default 4, number of cycles a pending read may wait before it takes priority over writes.
REQ-003 pclk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 wr_req  input  1  camera write strobe, one byte per cycle when high.
REQ-006 wr_addr  input  20  camera write address.
REQ-007 wr_data  input  8  camera pixel byte.
REQ-008 wr_overflow  output  1  one-cycle pulse when a write is dropped.
REQ-009 rd_req  input  1  display read request; held high with rd_addr stable until accepted.
REQ-010 rd_addr  input  20  display read address.
REQ-011 rd_ready  output  1  read accepted this cycle.
REQ-012 rd_data  output  8  returned pixel byte.
REQ-013 rd_valid  output  1  rd_data valid this cycle.
REQ-014 mem_en, mem_we  output  1 each  single-port RAM enable and write enable, registered.
REQ-015 mem_addr  output  20, mem_wdata  output  8, mem_rdata  input  8  RAM bus; RAM read latency is 1 cycle.

Function
REQ-016 Writes SHALL enter a 2-entry FIFO holding {addr,data}; a write arriving when the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL pulse wr_overflow in the next cycle.
REQ-017 A simultaneous push and pop on a full FIFO SHALL accept the push (pop before push).
REQ-018 A write with wr_addr >= FB_DEPTH SHALL be discarded without a FIFO push or RAM access, and SHALL NOT pulse wr_overflow.
REQ-019 Arbitration each cycle: a read SHALL be granted if rd_req=1 and (FIFO empty or wait_cnt >= STARVE_LIMIT); otherwise a non-empty FIFO SHALL pop one write; otherwise the cycle is idle.
REQ-020 wait_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle rd_req=1 and no read is granted; it SHALL clear on a read grant or when rd_req=0.
REQ-021 rd_ready SHALL be combinational and high exactly in the grant cycle; at most one RAM access SHALL be issued per cycle.
REQ-022 A granted access SHALL appear on mem_en/mem_we/mem_addr/mem_wdata in the following cycle; mem_en=0 when idle.
REQ-023 rd_valid SHALL pulse exactly 3 cycles after the rd_ready cycle, with rd_data = RAM content at rd_addr; reads return data in grant order.
REQ-024 A granted read with rd_addr >= FB_DEPTH SHALL issue no RAM access and SHALL return rd_data=0 with rd_valid at the same 3-cycle latency.
REQ-025 Back-to-back reads, one per cycle, SHALL be sustained when the FIFO is empty.

Reset
REQ-026 While reset=0 at a rising edge: FIFO empty, wait_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_ready=0, rd_valid=0, rd_data=0, wr_overflow=0; the in-flight read pipeline SHALL be flushed with no rd_valid.
REQ-027 wr_req and rd_req SHALL be ignored during the reset cycle.

Configuration
REQ-028 With macro FB_ARB_STATS_EN defined, the block SHALL add outputs drop_count (16 bits, increments per dropped write, saturates at 65535) and starve_count (16 bits, increments per read grant forced by REQ-019's wait_cnt condition, saturates); both zero on reset.
REQ-029 Without FB_ARB_STATS_EN, those ports and counters SHALL NOT exist and behaviour is otherwise identical.

Verification
REQ-030 Write 0x5A to addr 100 with idle reads, then read addr 100 -> mem write one cycle after wr_req; rd_valid 3 cycles after rd_ready with rd_data=0x5A.
REQ-031 Continuous wr_req for 20 cycles plus rd_req held high from cycle 0 -> rd_ready high exactly at cycle 4 (STARVE_LIMIT=4); one write stays buffered and no drop occurs.
REQ-032 Three writes while reads are forced granted (wait_cnt saturated) -> third write dropped, wr_overflow pulses once, drop_count=1 with FB_ARB_STATS_EN.
REQ-033 wr_addr=307200 -> no mem_en, no wr_overflow; rd_addr=307200 -> rd_data=0, rd_valid at +3 cycles, no mem_en.
REQ-034 Assert reset=0 one cycle after a read grant -> no rd_valid is ever produced for that read; all outputs at reset values next cycle.
